// File: rtl/seq_detect_param.sv
// seq_detect_param: W-bit serial pattern detector with qualified input,
// overlap mode and a saturating match counter.
//
// Parameters: W (pattern length), PATTERN (PATTERN[W-1] arrives first),
//   CNT_W (match counter width).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   x, x_vld   serial bit and its qualifier
//   overlap    1 = overlapping detection, 0 = restart after a match
//   clr        synchronous clear of history, counter and match
//   match      registered one-cycle pulse after the completing bit
//   match_cnt  saturating match count since reset/clr
//   cnt_sat    high while match_cnt is all ones
// Macro SEQ_DET_PROG_EN adds pat_in/pat_ld and a loadable pattern register.
module seq_detect_param #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_vld,
  input  logic             overlap,
  input  logic             clr,
`ifdef SEQ_DET_PROG_EN
  input  logic [W-1:0]     pat_in,
  input  logic             pat_ld,
`endif
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int LW = $clog2(W + 1);
  localparam logic [LW-1:0] LEN_FULL = LW'(W);

  logic [W-1:0]     hist_q, hist_d;
  logic [LW-1:0]    len_q, len_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [W-1:0]     pat;

`ifdef SEQ_DET_PROG_EN
  logic [W-1:0]     pat_q, pat_d;
  assign pat = pat_q;
`else
  assign pat = PATTERN;
`endif

  logic [W-1:0]  hist_upd;
  logic [LW-1:0] len_upd;
  logic          hit;

  // Candidate state if the current bit is accepted.
  assign hist_upd = {hist_q[W-2:0], x};
  assign len_upd  = (len_q == LEN_FULL) ? len_q : len_q + LW'(1);
  assign hit      = (hist_upd == pat) && (len_upd == LEN_FULL);

  always_comb begin
    hist_d  = hist_q;
    len_d   = len_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
`ifdef SEQ_DET_PROG_EN
    pat_d   = pat_q;
`endif
    if (clr) begin
      hist_d = '0;
      len_d  = '0;
      cnt_d  = '0;
    end
`ifdef SEQ_DET_PROG_EN
    else if (pat_ld) begin
      pat_d  = pat_in;
      hist_d = '0;
      len_d  = '0;
    end
`endif
    else if (x_vld) begin
      hist_d  = hist_upd;
      // Non-overlap mode forgets progress once a match completes.
      len_d   = (hit && !overlap) ? '0 : len_upd;
      match_d = hit;
      if (hit && !sat_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q  <= '0;
      len_q   <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
`ifdef SEQ_DET_PROG_EN
      pat_q   <= PATTERN;
`endif
    end else begin
      hist_q  <= hist_d;
      len_q   <= len_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
`ifdef SEQ_DET_PROG_EN
      pat_q   <= pat_d;
`endif
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed table-driven bench for seq_detect_param,
// plus hand-written saturation and programmable-pattern sequences.
module tb_seq_detect_param;

  logic       clk;
  logic       rst;
  logic       x;
  logic       x_vld;
  logic       overlap;
  logic       clr;
  logic [3:0] pat_in;
  logic       pat_ld;

  logic       match;
  logic [7:0] match_cnt;
  logic       cnt_sat;
  logic       s_match;
  logic [1:0] s_cnt;
  logic       s_sat;

  int total;
  int bad;

  seq_detect_param dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_vld     (x_vld),
    .overlap   (overlap),
    .clr       (clr),
`ifdef SEQ_DET_PROG_EN
    .pat_in    (pat_in),
    .pat_ld    (pat_ld),
`endif
    .match     (match),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat)
  );

  seq_detect_param #(.CNT_W(2)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_vld     (x_vld),
    .overlap   (overlap),
    .clr       (clr),
`ifdef SEQ_DET_PROG_EN
    .pat_in    (pat_in),
    .pat_ld    (pat_ld),
`endif
    .match     (s_match),
    .match_cnt (s_cnt),
    .cnt_sat   (s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic c;
    logic v;
    logic xx;
    logic o;
    logic em;
    int   ec;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic r, input logic c,
                              input logic v, input logic xx,
                              input logic o, input logic em,
                              input int ec);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.xx = xx;
    t.o = o; t.em = em; t.ec = ec;
    tv.push_back(t);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v,
                      input logic xx, input logic o);
    rst = r; clr = c; x_vld = v; x = xx; overlap = o;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic xx);
    step(1'b1, 1'b0, 1'b1, xx, 1'b1);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; clr = 1'b0; x = 1'b0; x_vld = 1'b0;
    overlap = 1'b1; pat_in = 4'b0000; pat_ld = 1'b0;

    // reset with a valid 1 presented, then idle
    add(0,0,1,1,1, 0,0);
    add(0,0,1,1,1, 0,0);
    add(1,0,0,0,1, 0,0);
    add(1,0,0,0,1, 0,0);
    add(1,0,0,0,1, 0,0);
    // overlap: 1 0 1 1 0 1 1
    add(1,0,1,1,1, 0,0);
    add(1,0,1,0,1, 0,0);
    add(1,0,1,1,1, 0,0);
    add(1,0,1,1,1, 1,1);
    add(1,0,1,0,1, 0,1);
    add(1,0,1,1,1, 0,1);
    add(1,0,1,1,1, 1,2);
    add(1,0,0,0,1, 0,2);
    add(1,1,0,0,1, 0,0);
    // non-overlap: 1 0 1 1 0 1 1, then 1 0 1 1
    add(1,0,1,1,0, 0,0);
    add(1,0,1,0,0, 0,0);
    add(1,0,1,1,0, 0,0);
    add(1,0,1,1,0, 1,1);
    add(1,0,1,0,0, 0,1);
    add(1,0,1,1,0, 0,1);
    add(1,0,1,1,0, 0,1);
    add(1,0,1,1,0, 0,1);
    add(1,0,1,0,0, 0,1);
    add(1,0,1,1,0, 0,1);
    add(1,0,1,1,0, 1,2);
    // gapped valid: 1 0 <gap x3> 1 1
    add(1,1,0,0,1, 0,0);
    add(1,0,1,1,1, 0,0);
    add(1,0,1,0,1, 0,0);
    add(1,0,0,1,1, 0,0);
    add(1,0,0,1,1, 0,0);
    add(1,0,0,1,1, 0,0);
    add(1,0,1,1,1, 0,0);
    add(1,0,1,1,1, 1,1);
    add(1,0,0,0,1, 0,1);
    // clr mid-pattern: 1 0 1, clr with valid 1, then 1
    add(1,1,0,0,1, 0,0);
    add(1,0,1,1,1, 0,0);
    add(1,0,1,0,1, 0,0);
    add(1,0,1,1,1, 0,0);
    add(1,1,1,1,1, 0,0);
    add(1,0,1,1,1, 0,0);
    // reset mid-pattern: same with rst
    add(1,1,0,0,1, 0,0);
    add(1,0,1,1,1, 0,0);
    add(1,0,1,0,1, 0,0);
    add(1,0,1,1,1, 0,0);
    add(0,0,1,1,1, 0,0);
    add(1,0,1,1,1, 0,0);

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].c, tv[i].v, tv[i].xx, tv[i].o);
      chk($sformatf("v%0d.match", i), int'(match), int'(tv[i].em));
      chk($sformatf("v%0d.cnt", i), int'(match_cnt), tv[i].ec);
      chk($sformatf("v%0d.sat", i), int'(cnt_sat), 0);
    end

    // saturation on the 2-bit counter instance
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat.clr0", int'(s_cnt), 0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("sat.m1.match", int'(s_match), 1);
    chk("sat.m1.cnt", int'(s_cnt), 1);
    chk("sat.m1.sat", int'(s_sat), 0);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = k + 2;
      bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
      chk($sformatf("sat.m%0d.match", n), int'(s_match), 1);
      chk($sformatf("sat.m%0d.cnt", n), int'(s_cnt), (n > 3) ? 3 : n);
      chk($sformatf("sat.m%0d.sat", n), int'(s_sat), (n >= 3) ? 1 : 0);
      chk($sformatf("sat.m%0d.wide", n), int'(match_cnt), n);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat.hold.cnt", int'(s_cnt), 3);
    chk("sat.hold.match", int'(s_match), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat.clr.cnt", int'(s_cnt), 0);
    chk("sat.clr.sat", int'(s_sat), 0);

`ifdef SEQ_DET_PROG_EN
    // load 0110; the valid bit in the load cycle is discarded
    pat_in = 4'b0110; pat_ld = 1'b1;
    bit_in(1'b1);
    pat_ld = 1'b0;
    chk("prog.ld.match", int'(match), 0);
    chk("prog.ld.cnt", int'(match_cnt), 0);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("prog.pre.match", int'(match), 0);
    bit_in(1'b0);
    chk("prog.hit.match", int'(match), 1);
    chk("prog.hit.cnt", int'(match_cnt), 1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    bit_in(1'b1);
    chk("prog.old.match", int'(match), 0);
    chk("prog.old.cnt", int'(match_cnt), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
